cs_host_sequencer: RTL and testbench

Host-side initiator for the computation storage (CS) unit. It accepts one command at a time over a valid/ready port and drives the CS control bundle: `addA`, `addB`, `addC`, `operation_select`, `RD_en1`, `RD_en2`, `WR_en1` and the bidirectional `DQ` bus. It waits for the unit's `seq_finished` and returns a response with data or an error. It sits between the system/test master and the CS memory, and it is the only driver of the CS control signals.

---
 rtl/cs_pkg.sv | 29 ++
 rtl/cs_wait_timer.sv | 34 +++
 rtl/cs_host_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_cs_host_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared types and default parameters for the computation-storage host sequencer.
package cs_pkg;

    localparam int DEF_MEM_WIDTH      = 8;
    localparam int DEF_MEM_DEPTH      = 16;
    localparam int DEF_NO_OPERATIONS  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        CMD_COMPUTE = 2'b00,
        CMD_WRITE   = 2'b01,
        CMD_READ    = 2'b10,
        CMD_RSVD    = 2'b11
    } cmd_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } seq_state_e;

    // A command is rejected at accept time if its type is reserved or its op is out of range.
    function automatic logic cmd_legal(input logic [1:0] t, input int unsigned op,
                                       input int unsigned n_ops);
        return (t != CMD_RSVD) && !((t == CMD_COMPUTE) && (op >= n_ops));
    endfunction

endpackage

// File: rtl/cs_wait_timer.sv
// Counts cycles spent waiting for the CS unit; expired flags the final allowed cycle.
import cs_pkg::*;

module cs_wait_timer #(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && (cnt_q != LAST))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/cs_host_sequencer.sv
// Single-outstanding command initiator driving the CS control bundle and returning a response.
import cs_pkg::*;

module cs_host_sequencer #(
    parameter int MEM_WIDTH      = DEF_MEM_WIDTH,
    parameter int MEM_DEPTH      = DEF_MEM_DEPTH,
    parameter int NO_OPERATIONS  = DEF_NO_OPERATIONS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int AW = $clog2(MEM_DEPTH),
    localparam int OW = $clog2(NO_OPERATIONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_type,
    input  logic [AW-1:0]        cmd_addA,
    input  logic [AW-1:0]        cmd_addB,
    input  logic [AW-1:0]        cmd_addC,
    input  logic [OW-1:0]        cmd_op,
    input  logic [MEM_WIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MEM_WIDTH-1:0] rsp_data,
    output logic                 rsp_err,
    output logic [AW-1:0]        addA,
    output logic [AW-1:0]        addB,
    output logic [AW-1:0]        addC,
    output logic [OW-1:0]        operation_select,
    output logic                 RD_en1,
    output logic                 RD_en2,
    output logic                 WR_en1,
    input  logic                 seq_finished,
    inout  wire  [MEM_WIDTH-1:0] DQ,
    output logic [15:0]          done_count,
    output logic [7:0]           err_count
);

    seq_state_e           state_q, state_d;
    cmd_type_e            type_q, type_d;
    logic [MEM_WIDTH-1:0] wdata_q, wdata_d;
    logic [AW-1:0]        addA_q, addA_d, addB_q, addB_d, addC_q, addC_d;
    logic [OW-1:0]        op_q, op_d;
    logic                 rd1_q, rd1_d, rd2_q, rd2_d, wr_q, wr_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [MEM_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [15:0]          done_q, done_d;
    logic [7:0]           errc_q, errc_d;
    logic                 tmr_clear, tmr_en, tmr_expired;

    cs_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        wdata_d     = wdata_q;
        addA_d      = addA_q;
        addB_d      = addB_q;
        addC_d      = addC_q;
        op_d        = op_q;
        rd1_d       = 1'b0;
        rd2_d       = 1'b0;
        wr_d        = 1'b0;
        cmd_ready_d = cmd_ready_q;
        dq_oe_d     = dq_oe_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        done_d      = done_q;
        errc_d      = errc_q;
        tmr_clear   = 1'b1;
        tmr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    type_d      = cmd_type_e'(cmd_type);
                    wdata_d     = cmd_wdata;
                    addA_d      = cmd_addA;
                    addB_d      = cmd_addB;
                    addC_d      = cmd_addC;
                    op_d        = cmd_op;
                    if (cmd_legal(cmd_type, int'(cmd_op), NO_OPERATIONS)) begin
                        // Strobes are registered here so they appear exactly during ISSUE.
                        state_d = ISSUE;
                        rd1_d   = (cmd_type == CMD_COMPUTE) || (cmd_type == CMD_READ);
                        rd2_d   = (cmd_type == CMD_COMPUTE);
                        wr_d    = (cmd_type == CMD_COMPUTE) || (cmd_type == CMD_WRITE);
                        dq_oe_d = (cmd_type == CMD_WRITE);
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                tmr_clear = 1'b0;
                tmr_en    = 1'b1;
                // A completion on the expiry cycle still wins over the timeout.
                if (seq_finished) begin
                    state_d     = RESP;
                    dq_oe_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = (type_q == CMD_READ) ? DQ : '0;
                end else if (tmr_expired) begin
                    state_d     = RESP;
                    dq_oe_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    if (rsp_err_q)
                        errc_d = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
                    else
                        done_d = (done_q == 16'hFFFF) ? done_q : done_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            type_q      <= CMD_COMPUTE;
            wdata_q     <= '0;
            addA_q      <= '0;
            addB_q      <= '0;
            addC_q      <= '0;
            op_q        <= '0;
            rd1_q       <= 1'b0;
            rd2_q       <= 1'b0;
            wr_q        <= 1'b0;
            cmd_ready_q <= 1'b1;
            dq_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            done_q      <= '0;
            errc_q      <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            wdata_q     <= wdata_d;
            addA_q      <= addA_d;
            addB_q      <= addB_d;
            addC_q      <= addC_d;
            op_q        <= op_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            wr_q        <= wr_d;
            cmd_ready_q <= cmd_ready_d;
            dq_oe_q     <= dq_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            done_q      <= done_d;
            errc_q      <= errc_d;
        end
    end

    assign DQ = dq_oe_q ? wdata_q : 'z;

    assign cmd_ready        = cmd_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_err          = rsp_err_q;
    assign addA             = addA_q;
    assign addB             = addB_q;
    assign addC             = addC_q;
    assign operation_select = op_q;
    assign RD_en1           = rd1_q;
    assign RD_en2           = rd2_q;
    assign WR_en1           = wr_q;
    assign done_count       = done_q;
    assign err_count        = errc_q;

endmodule

// File: tb/tb_cs_host_sequencer.sv
// Randomized scoreboard bench for cs_host_sequencer with a behavioural CS unit model.
import cs_pkg::*;

module tb_cs_host_sequencer;

    localparam int MW = 8;
    localparam int MD = 16;
    localparam int NO = 4;
    localparam int TO = 8;
    localparam int AW = 4;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_type = '0;
    logic [AW-1:0] cmd_addA = '0, cmd_addB = '0, cmd_addC = '0;
    logic [OW-1:0] cmd_op = '0;
    logic [MW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [MW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] addA, addB, addC;
    logic [OW-1:0] operation_select;
    logic          RD_en1, RD_en2, WR_en1;
    logic          seq_finished = 1'b0;
    wire  [MW-1:0] DQ;
    logic [15:0]   done_count;
    logic [7:0]    err_count;
    logic [MW-1:0] tb_dq = '0;
    logic          tb_dq_en = 1'b0;

    assign DQ = tb_dq_en ? tb_dq : 'z;

    always #5 clk = ~clk;

    cs_host_sequencer #(.MEM_WIDTH(MW), .MEM_DEPTH(MD), .NO_OPERATIONS(NO),
                        .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_addA(cmd_addA), .cmd_addB(cmd_addB), .cmd_addC(cmd_addC),
        .cmd_op(cmd_op), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .addA(addA), .addB(addB), .addC(addC),
        .operation_select(operation_select), .RD_en1(RD_en1), .RD_en2(RD_en2), .WR_en1(WR_en1),
        .seq_finished(seq_finished), .DQ(DQ), .done_count(done_count), .err_count(err_count)
    );

    typedef struct {
        logic [1:0]    t;
        logic [AW-1:0] a, b, c;
        logic [OW-1:0] op;
        logic [MW-1:0] wd;
        int            d;   // cycles from strobe to seq_finished; 0 = never
    } cmd_t;

    typedef struct {
        logic [MW-1:0] data;
        logic          err;
        int            at;
    } rsp_t;

    rsp_t          exp_rsp[$];
    cmd_t          exp_cs[$];
    logic [MW-1:0] ref_mem[MD];
    logic [MW-1:0] cs_mem[MD];
    int            checks = 0, errors = 0;
    int            cyc = 0;
    int            hold_low = 0;
    int            ref_done = 0, ref_err = 0;
    bit            model_abort = 1'b0;
    bit            in_rsp = 1'b0;
    bit            cnt_chk = 1'b0;
    rsp_t          cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response handshake pacing: random backpressure, or forced low on request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_low > 0) begin
                rsp_ready = 1'b0;
                hold_low--;
            end else begin
                rsp_ready = ($urandom_range(3) != 0);
            end
        end
    end

    // Behavioural CS unit: checks the strobe bundle, then completes after c.d cycles.
    initial begin
        cmd_t c;
        int   dd;
        for (int i = 0; i < MD; i++) cs_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst && (RD_en1 || RD_en2 || WR_en1)) begin
                if (exp_cs.size() == 0) begin
                    chk("unexpected_strobe", {RD_en1, RD_en2, WR_en1}, 0);
                end else begin
                    c = exp_cs.pop_front();
                    case (c.t)
                        2'b00: begin
                            chk("cmp_strobes", {RD_en1, RD_en2, WR_en1}, 3'b111);
                            chk("cmp_addA", addA, c.a);
                            chk("cmp_addB", addB, c.b);
                            chk("cmp_addC", addC, c.c);
                            chk("cmp_op", operation_select, c.op);
                        end
                        2'b01: begin
                            chk("wr_strobes", {RD_en1, RD_en2, WR_en1}, 3'b001);
                            chk("wr_addC", addC, c.c);
                            chk("wr_dq_issue", DQ, c.wd);
                        end
                        default: begin
                            chk("rd_strobes", {RD_en1, RD_en2, WR_en1}, 3'b100);
                            chk("rd_addA", addA, c.a);
                        end
                    endcase
                    dd = (c.d != 0) ? c.d : TO + 2;
                    for (int k = 1; k <= dd; k++) begin
                        @(posedge clk);
                        #1;
                        if (k == dd) begin
                            seq_finished = 1'b1;
                            if (c.t == 2'b10 && c.d != 0) begin
                                tb_dq    = cs_mem[c.a];
                                tb_dq_en = 1'b1;
                            end
                        end
                        @(negedge clk);
                        if (!model_abort) begin
                            if (k == 1) chk("strobe_one_cycle", {RD_en1, RD_en2, WR_en1}, 0);
                            if (c.t == 2'b01) begin
                                if (c.d != 0 || k <= TO) chk("wr_dq_wait", DQ, c.wd);
                                else if (k == TO + 1) chk("dq_released_timeout", DQ === 8'bz, 1);
                            end
                        end
                        if (k == dd && c.t == 2'b01 && c.d != 0) cs_mem[c.c] = DQ;
                    end
                    @(posedge clk);
                    #1;
                    seq_finished = 1'b0;
                    tb_dq_en     = 1'b0;
                end
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_rsp  = 1'b0;
                cnt_chk = 1'b0;
            end else if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    if (exp_rsp.size() == 0) begin
                        chk("unexpected_rsp", rsp_valid, 0);
                        cur.data = rsp_data;
                        cur.err  = rsp_err;
                    end else begin
                        cur = exp_rsp.pop_front();
                        chk("rsp_cycle", cyc, cur.at);
                        chk("dq_released", DQ === 8'bz, 1);
                    end
                end
                chk("rsp_data", rsp_data, cur.data);
                chk("rsp_err", rsp_err, cur.err);
                chk("cmd_ready_busy", cmd_ready, 0);
                if (rsp_ready) begin
                    in_rsp = 1'b0;
                    if (cur.err) ref_err  = (ref_err == 255) ? ref_err : ref_err + 1;
                    else         ref_done = (ref_done == 65535) ? ref_done : ref_done + 1;
                    cnt_chk = 1'b1;
                end
            end else if (cnt_chk) begin
                cnt_chk = 1'b0;
                chk("done_count", done_count, ref_done);
                chk("err_count", err_count, ref_err);
            end
        end
    end

    task automatic issue(input cmd_t c);
        rsp_t r;
        bit   legal, ok;
        int   n;
        legal = (c.t != 2'b11) && !(c.t == 2'b00 && int'(c.op) >= NO);
        ok    = legal && (c.d != 0);
        if (c.t == 2'b11) hold_low = 6;
        cmd_valid = 1'b1;
        cmd_type  = c.t;
        cmd_addA  = c.a;
        cmd_addB  = c.b;
        cmd_addC  = c.c;
        cmd_op    = c.op;
        cmd_wdata = c.wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready || n > 300) break;
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        r.err  = !ok;
        r.data = (ok && c.t == 2'b10) ? ref_mem[c.a] : '0;
        r.at   = cyc + (!legal ? 1 : (c.d == 0 ? TO + 2 : c.d + 2));
        if (ok && c.t == 2'b01) ref_mem[c.c] = c.wd;
        exp_rsp.push_back(r);
        if (legal) exp_cs.push_back(c);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    function automatic cmd_t mk(input logic [1:0] t, input int a, input int b, input int c,
                                input int op, input int wd, input int d);
        cmd_t x;
        x.t = t; x.a = AW'(a); x.b = AW'(b); x.c = AW'(c);
        x.op = OW'(op); x.wd = MW'(wd); x.d = d;
        return x;
    endfunction

    initial begin
        cmd_t c;
        int   n;
        for (int i = 0; i < MD; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp", {rsp_data, rsp_err}, 0);
        chk("rst_strobes", {RD_en1, RD_en2, WR_en1}, 0);
        chk("rst_addr", {addA, addB, addC, operation_select}, 0);
        chk("rst_dq_z", DQ === 8'bz, 1);
        chk("rst_counts", {done_count, err_count}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(mk(2'b01, 0, 0, 5, 0, 8'hA5, 2));     // write 0xA5 -> [5]
        issue(mk(2'b10, 5, 0, 0, 0, 0, 1));         // read [5], fastest completion
        issue(mk(2'b00, 1, 2, 3, 2, 0, 3));         // compute
        issue(mk(2'b01, 0, 0, 7, 0, 8'h3C, 0));     // write that times out
        issue(mk(2'b10, 7, 0, 0, 0, 0, 2));         // [7] must still be 0
        issue(mk(2'b11, 4, 4, 4, 1, 8'hFF, 2));     // reserved type, backpressured
        issue(mk(2'b01, 0, 0, 9, 0, 8'h5A, TO));    // completion on the expiry cycle
        issue(mk(2'b10, 9, 0, 0, 0, 0, TO));

        for (int i = 0; i < 40; i++) begin
            c.t  = 2'($urandom_range(3));
            c.a  = AW'($urandom);
            c.b  = AW'($urandom);
            c.c  = AW'($urandom);
            c.op = OW'($urandom);
            c.wd = MW'($urandom);
            c.d  = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(TO, 1));
            issue(c);
        end

        n = 0;
        while ((exp_rsp.size() != 0 || in_rsp || cnt_chk) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", exp_rsp.size(), 0);
        repeat (14) @(posedge clk);
        #1;

        // Reset in the middle of a WRITE's WAIT phase.
        model_abort = 1'b1;
        c = mk(2'b01, 0, 0, 2, 0, 8'hC3, 0);
        exp_cs.push_back(c);
        cmd_valid = 1'b1; cmd_type = c.t; cmd_addC = c.c; cmd_wdata = c.wd;
        @(negedge clk);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_dq", DQ, 8'hC3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dq_z", DQ === 8'bz, 1);
        chk("midrst_strobes", {RD_en1, RD_en2, WR_en1}, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_counts", {done_count, err_count}, 0);
        rst = 1'b0;
        ref_done = 0;
        ref_err  = 0;
        repeat (14) @(negedge clk);
        chk("late_pulse_ignored", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
